// File: rtl/spi_slave.sv
// SPI responder on the shared clk_div: LSB-first receive/transmit of FRAME-bit words.
// Optional start/stop bit check enabled by defining SPI_SLAVE_FRAME_CHECK_EN.
module spi_slave #(
    parameter int package_size = 8,
    localparam int FRAME = package_size + 2
) (
    input  logic             clk_div,
    input  logic             rst_n,
    input  logic             SS,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [FRAME-1:0] tx_data,
    input  logic             tx_load,
    output logic             tx_busy,
    output logic [FRAME-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_abort
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    ,
    output logic             frame_err
`endif
);

    localparam int CNT_W = $clog2(FRAME + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FRAME-1:0]   rx_sh_q, rx_sh_d;
    logic [FRAME-1:0]   tx_sh_q, tx_sh_d;
    logic [FRAME-1:0]   tx_next_s;
    logic               miso_q, miso_d;
    logic               busy_q, busy_d;
    logic [FRAME-1:0]   rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               abort_q, abort_d;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    logic               frame_err_q, frame_err_d;
`endif

    // A load on the same edge as frame start must win, so bit 0 comes from tx_data directly.
    assign tx_next_s = tx_load ? tx_data : tx_sh_q;

    // Next-state and next-output logic for the frame FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        miso_d     = miso_q;
        busy_d     = busy_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        abort_d    = 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!SS) begin
                    rx_sh_d = {MOSI, rx_sh_q[FRAME-1:1]};
                    cnt_d   = CNT_W'(1);
                    busy_d  = 1'b1;
                    miso_d  = tx_next_s[0];
                    tx_sh_d = {1'b0, tx_next_s[FRAME-1:1]};
                    state_d = SHIFT;
                end else begin
                    tx_sh_d = tx_next_s;
                    miso_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (SS) begin
                    abort_d = 1'b1;
                    rx_sh_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    rx_sh_d = {MOSI, rx_sh_q[FRAME-1:1]};
                    miso_d  = tx_sh_q[0];
                    tx_sh_d = {1'b0, tx_sh_q[FRAME-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q + CNT_W'(1) == CNT_W'(FRAME)) begin
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            DONE: begin
                rx_data_d  = rx_sh_q;
                rx_valid_d = 1'b1;
                busy_d     = 1'b0;
                cnt_d      = '0;
                miso_d     = 1'b0;
                state_d    = IDLE;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
                frame_err_d = rx_sh_q[0] | ~rx_sh_q[FRAME-1];
`endif
            end
            default: begin
                cnt_d   = '0;
                busy_d  = 1'b0;
                miso_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            abort_q    <= abort_d;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign MISO        = miso_q;
    assign tx_busy     = busy_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_abort = abort_q;
`ifdef SPI_SLAVE_FRAME_CHECK_EN
    assign frame_err   = frame_err_q;
`endif

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Responder end of the team's single-clock SPI link. Sits opposite the SPI master on the same clk_div domain.
- Deserialises frames arriving LSB-first on MOSI while SS is low, and presents each complete word with a one-cycle valid strobe.
- At the same time, shifts a preloaded response word out on MISO, LSB-first.
- No separate SCLK is used; both ends run on the shared clk_div.

Parameters:
- package_size, 8, payload bits. Frame width FRAME = package_size+2 bits on the wire.

Ports:
- clk_div  input  1  system/bit clock; every action is on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- SS  input  1  slave select, active low; frame is active while 0
- MOSI  input  1  serial data from master, LSB first
- MISO  output  1  serial data to master, LSB first
- tx_data  input  FRAME  response word to transmit in the next frame
- tx_load  input  1  capture tx_data into the transmit shifter (honoured only in IDLE)
- tx_busy  output  1  high from the first active SS cycle until the frame completes or aborts
- rx_data  output  FRAME  last fully received frame
- rx_valid  output  1  one-cycle pulse when rx_data updates
- frame_abort  output  1  one-cycle pulse when SS rises mid-frame

Behaviour:
- Reset (rst_n=0, async): state=IDLE, bit counter=0, rx shifter=0, tx shifter=0, MISO=0, tx_busy=0, rx_data=0, rx_valid=0, frame_abort=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If tx_load=1, tx shifter <= tx_data.
  - If SS=0 on a rising edge, treat that edge as bit 0:
    - sample MOSI into rx shifter bit FRAME-1 (shift-right fill);
    - set counter=1 and tx_busy=1;
    - MISO <= tx shifter[0], then shift the tx shifter right by one;
    - go to SHIFT.
  - If tx_load and SS=0 occur on the same edge, the new tx_data is loaded first and its bit0 goes out.
- SHIFT, each edge with SS=0:
  - shift MOSI in and drive the next tx bit on MISO (registered);
  - counter increments;
  - when counter reaches FRAME, go to DONE.
- DONE (1 cycle):
  - rx_data <= rx shifter; rx_valid=1; tx_busy=0; counter=0;
  - return to IDLE.
  - If SS is still 0 in DONE, that edge is not sampled. The master must deassert SS for at least one cycle between frames.
- Abort: SS=1 in SHIFT with counter<FRAME:
  - frame_abort=1 for one cycle; rx shifter discarded; rx_data unchanged; counter=0; tx_busy=0; MISO=0;
  - return to IDLE. The tx shifter is not reloaded automatically.
- Bit order: the first sampled bit becomes rx_data[0], the last becomes rx_data[FRAME-1].
- MISO is 0 whenever state=IDLE and no frame has started.
- Latency: rx_valid asserts on the edge after the FRAME-th sampled bit.
- tx_load is ignored outside IDLE.

Optional Feature:
- Macro SPI_SLAVE_FRAME_CHECK_EN.
- When defined:
  - adds output frame_err (1 bit), asserted alongside rx_valid when received bit0 != 0 (start bit) or bit FRAME-1 != 1 (stop bit);
  - rx_data still updates;
  - frame_err reset value is 0.
- When undefined: no frame_err port and no check logic.

Test Plan:
- Reset mid-frame: after 4 bits, pulse rst_n=0 -> all outputs 0 immediately; next full frame 10'h2A5 -> rx_data=10'h2A5.
- Receive (package_size=8): SS low 10 cycles, MOSI sends 10'h3C3 LSB-first -> rx_data=10'h3C3, rx_valid high exactly 1 cycle, on the edge after bit 9.
- Transmit: tx_load with tx_data=10'h155 in IDLE, then a 10-bit frame -> MISO sequence 1,0,1,0,1,0,1,0,1,0; tx_busy high 10 cycles.
- Abort: SS rises after 5 bits -> frame_abort 1-cycle pulse, rx_valid stays 0, rx_data keeps previous value, state IDLE.
- Back-to-back: two frames 10'h001 and 10'h3FF separated by 1 idle SS-high cycle -> two rx_valid pulses with correct data; tx_load ignored while tx_busy.
- SPI_SLAVE_FRAME_CHECK_EN: frame 10'h201 (start=1) -> frame_err=1 with rx_valid; frame 10'h200 -> frame_err=0.
